// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the result sources (pipeline WB, mul/div) and the regfile arbiter.
// The slave modport is the arbiter side; the master modport is the source/regfile/decode side.
interface rf_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [4:0]  q_addr;
  logic        q_pending;
  logic        a_hold;
  logic        rf_write;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_idata;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr,
    output b_ready, q_pending, a_hold, rf_write, rf_waddr, rf_idata, fwd_hit, fwd_data
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr,
    input  b_ready, q_pending, a_hold, rf_write, rf_waddr, rf_idata, fwd_hit, fwd_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: pipeline WB (A) has priority, mul/div results (B) are queued.
// Optional write forwarding to decode is enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rf_wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(DEPTH);

  logic [4:0]       mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;
  logic [SW-1:0]    starve_cnt;
  logic             hold_q;

  logic             vld_p1;
  logic [4:0]       waddr_p1;
  logic [31:0]      wdata_p1;

  logic             a_act;
  logic             b_rdy;
  logic             push;
  logic             live_any;
  logic             do_pop;
  logic             pop_wr;
  logic             found;
  logic [PW-1:0]    sel;
  logic [PW-1:0]    idx;
  logic [PW:0]      nscan;
  logic [PW:0]      npop;
  logic [DEPTH-1:0] inval;
  logic [DEPTH-1:0] pend;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STARVE_LIM) ? v : v + SW'(1);
  endfunction

  assign a_act    = bus.a_valid && (bus.a_addr != 5'd0);
  assign b_rdy    = (count != FULL_CNT);
  assign push     = bus.b_valid && b_rdy && (bus.b_addr != 5'd0);
  assign live_any = |live;
  assign do_pop   = !a_act && (count != '0);
  assign pop_wr   = do_pop && found;
  assign npop     = do_pop ? nscan : '0;

  // Find the oldest live entry; dead entries ahead of it are retired in the same pop.
  always_comb begin
    found = 1'b0;
    sel   = head;
    idx   = head;
    nscan = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (!found && ((PW+1)'(i) < count)) begin
        nscan = (PW+1)'(i + 1);
        if (live[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end
  end

  always_comb begin
    inval = '0;
    pend  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      inval[i] = a_act && live[i] && (mem_addr[i] == bus.a_addr);
      pend[i]  = live[i] && (mem_addr[i] == bus.q_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= bus.b_addr;
      mem_data[tail] <= bus.b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      live       <= '0;
      starve_cnt <= '0;
      hold_q     <= 1'b0;
    end else begin
      head  <= head + npop[PW-1:0];
      tail  <= tail + PW'(push);
      count <= count - npop + (PW+1)'(push);
      for (int i = 0; i < DEPTH; i++) begin
        if (inval[i]) live[i] <= 1'b0;
      end
      if (pop_wr) live[sel]  <= 1'b0;
      if (push)   live[tail] <= 1'b1;

      starve_cnt <= (a_act && live_any) ? sat_inc(starve_cnt) : '0;
      if (pop_wr || !live_any)
        hold_q <= 1'b0;
      else if (starve_cnt == STARVE_LIM)
        hold_q <= 1'b1;
    end
  end

  // Stage p1: registered regfile write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else if (a_act) begin
      vld_p1   <= 1'b1;
      waddr_p1 <= bus.a_addr;
      wdata_p1 <= bus.a_data;
    end else if (pop_wr) begin
      vld_p1   <= 1'b1;
      waddr_p1 <= mem_addr[sel];
      wdata_p1 <= mem_data[sel];
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.b_ready   = b_rdy;
  assign bus.q_pending = (|pend) && (bus.q_addr != 5'd0);
  assign bus.a_hold    = hold_q;
  assign bus.rf_write  = vld_p1;
  assign bus.rf_waddr  = waddr_p1;
  assign bus.rf_idata  = wdata_p1;

`ifdef RF_WB_FWD_EN
  logic fwd_hit_c;
  assign fwd_hit_c    = vld_p1 && (waddr_p1 == bus.q_addr) && (bus.q_addr != 5'd0);
  assign bus.fwd_hit  = fwd_hit_c;
  assign bus.fwd_data = fwd_hit_c ? wdata_p1 : '0;
`else
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the write-back rules.
module tb_rf_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } ent_t;

  int n_assert = 0;
  int n_fail   = 0;

  ent_t        mq[$];
  int          m_cnt;
  bit          m_hold, m_wr;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  ent_t        nq[$];
  int          n_cnt;
  bit          n_hold, n_wr;
  logic [4:0]  n_waddr;
  logic [31:0] n_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cnt = 0; m_hold = 0; m_wr = 0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic check_outputs(input string tag);
    bit          ehit;
    logic [31:0] edata;
`ifdef RF_WB_FWD_EN
    ehit  = m_wr && (m_waddr == bus.q_addr) && (bus.q_addr != 5'd0);
    edata = ehit ? m_wdata : 32'd0;
`else
    ehit  = 1'b0;
    edata = 32'd0;
`endif
    chk({tag, ":rf_write"},  32'(bus.rf_write),  32'(m_wr));
    chk({tag, ":rf_waddr"},  32'(bus.rf_waddr),  32'(m_waddr));
    chk({tag, ":rf_idata"},  bus.rf_idata,       m_wdata);
    chk({tag, ":a_hold"},    32'(bus.a_hold),    32'(m_hold));
    chk({tag, ":b_ready"},   32'(bus.b_ready),   32'(mq.size() < DEPTH));
    chk({tag, ":q_pending"}, 32'(bus.q_pending), 32'(m_pending(bus.q_addr)));
    chk({tag, ":fwd_hit"},   32'(bus.fwd_hit),   32'(ehit));
    chk({tag, ":fwd_data"},  bus.fwd_data,       edata);
  endtask

  // Reference: A wins, otherwise the oldest still-valid queued result is written.
  task automatic model_step();
    bit   a_act, live_any, popped;
    ent_t e;
    nq = mq;
    n_wr = 1'b0; n_waddr = m_waddr; n_wdata = m_wdata;
    popped = 1'b0;
    live_any = 1'b0;
    foreach (mq[i]) if (mq[i].live) live_any = 1'b1;
    a_act = bus.a_valid && (bus.a_addr != 5'd0);
    if (a_act) begin
      foreach (nq[i]) if (nq[i].addr == bus.a_addr) nq[i].live = 1'b0;
      n_wr = 1'b1; n_waddr = bus.a_addr; n_wdata = bus.a_data;
    end else begin
      while (nq.size() > 0 && !popped) begin
        e = nq.pop_front();
        if (e.live) begin
          popped = 1'b1; n_wr = 1'b1; n_waddr = e.addr; n_wdata = e.data;
        end
      end
    end
    if (bus.b_valid && (mq.size() < DEPTH) && (bus.b_addr != 5'd0))
      nq.push_back('{bus.b_addr, bus.b_data, 1'b1});
    if (popped || !live_any)          n_hold = 1'b0;
    else if (m_cnt == STARVE_MAX - 1) n_hold = 1'b1;
    else                              n_hold = m_hold;
    if (a_act && live_any) n_cnt = (m_cnt == STARVE_MAX - 1) ? m_cnt : m_cnt + 1;
    else                   n_cnt = 0;
  endtask

  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic [4:0] qa);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    bus.q_addr  = qa;
  endtask

  // Entered and left at posedge+1.
  task automatic cycle(input string tag);
    #3;
    check_outputs(tag);
    model_step();
    @(posedge clk);
    #1;
    mq = nq; m_cnt = n_cnt; m_hold = n_hold;
    m_wr = n_wr; m_waddr = n_waddr; m_wdata = n_wdata;
  endtask

  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_outputs(tag);
    chk({tag, ":rf_write0"}, 32'(bus.rf_write), 32'd0);
    chk({tag, ":b_ready1"},  32'(bus.b_ready),  32'd1);
    chk({tag, ":pending0"},  32'(bus.q_pending), 32'd0);
    drive(0, 0, 0, 0, 0, 0, bus.q_addr);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #7;
    check_outputs("por");
    chk("por:rf_idata0", bus.rf_idata, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-stream with three entries queued behind a busy pipeline.
    drive(1, 5'd1, 32'h11, 1, 5'd5, 32'h55, 5'd6); cycle("t1_q1");
    drive(1, 5'd1, 32'h12, 1, 5'd6, 32'h66, 5'd6); cycle("t1_q2");
    drive(1, 5'd1, 32'h13, 1, 5'd7, 32'h77, 5'd6); cycle("t1_q3");
    drive(1, 5'd1, 32'h14, 0, 5'd0, 32'h0,  5'd6);
    #1 chk("t1_pending_before", 32'(bus.q_pending), 32'd1);
    do_reset("t1_rst");

    // Single B result with A idle: queued one cycle, written the next.
    drive(0, 0, 0, 1, 5'd5, 32'h12345678, 5'd5); cycle("t2_push");
    drive(0, 0, 0, 0, 0, 0, 5'd5);
    #1 chk("t2_queued", 32'(bus.q_pending), 32'd1);
    chk("t2_no_write_yet", 32'(bus.rf_write), 32'd0);
    cycle("t2_pop");
    chk("t2_write", 32'(bus.rf_write), 32'd1);
    chk("t2_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("t2_idata", bus.rf_idata, 32'h12345678);
    cycle("t2_idle");

    // Starvation: A every cycle keeps r7 queued until a_hold asserts.
    drive(1, 5'd3, 32'hA, 1, 5'd7, 32'hB, 5'd7); cycle("t3_push");
    drive(1, 5'd3, 32'hA, 0, 0, 0, 5'd7);
    repeat (STARVE_MAX) cycle("t3_block");
    chk("t3_hold_set", 32'(bus.a_hold), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 5'd7);
    cycle("t3_drop");
    chk("t3_b_write", 32'(bus.rf_write), 32'd1);
    chk("t3_b_waddr", 32'(bus.rf_waddr), 32'd7);
    chk("t3_b_idata", bus.rf_idata, 32'hB);
    chk("t3_hold_clr", 32'(bus.a_hold), 32'd0);
    cycle("t3_idle");

    // A younger write to a queued register kills the queued one.
    drive(1, 5'd2, 32'h22, 1, 5'd9, 32'h1, 5'd9); cycle("t4_push");
    drive(1, 5'd9, 32'h2, 0, 0, 0, 5'd9);
    #1 chk("t4_pending_before", 32'(bus.q_pending), 32'd1);
    cycle("t4_a");
    drive(0, 0, 0, 0, 0, 0, 5'd9);
    #1 chk("t4_a_data", bus.rf_idata, 32'h2);
    chk("t4_pending_after", 32'(bus.q_pending), 32'd0);
    cycle("t4_skip");
    chk("t4_no_stale", 32'(bus.rf_write), 32'd0);
    cycle("t4_idle");

    // Fill the queue, then offer more and a zero-address result.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 5'd1, 32'h100 + i, 1, 5'(10 + i), 32'h200 + i, 5'd10);
      cycle("t5_fill");
    end
    drive(1, 5'd1, 32'h1FF, 1, 5'd20, 32'hDEAD, 5'd20);
    #1 chk("t5_full", 32'(bus.b_ready), 32'd0);
    cycle("t5_reject");
    drive(1, 5'd1, 32'h1FE, 1, 5'd0, 32'hBEEF, 5'd20);
    cycle("t5_zero_full");
    chk("t5_still_full", 32'(bus.b_ready), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 5'd20);
    repeat (DEPTH + 2) cycle("t5_drain");
    drive(0, 0, 0, 1, 5'd0, 32'hBEEF, 5'd0);
    cycle("t5_zero_empty");
    drive(0, 0, 0, 0, 0, 0, 5'd0);
    cycle("t5_after_zero");
    chk("t5_zero_nowrite", 32'(bus.rf_write), 32'd0);

    // Forwarding of a landing regfile write.
    drive(1, 5'd4, 32'hCAFE, 0, 0, 0, 5'd4); cycle("t6_a");
    drive(0, 0, 0, 0, 0, 0, 5'd4);
`ifdef RF_WB_FWD_EN
    #1 chk("t6_fwd_hit", 32'(bus.fwd_hit), 32'd1);
    chk("t6_fwd_data", bus.fwd_data, 32'hCAFE);
`else
    #1 chk("t6_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    chk("t6_fwd_data", bus.fwd_data, 32'd0);
`endif
    cycle("t6_idle");

    // Random traffic with colliding register numbers.
    for (int n = 0; n < 600; n++) begin
      bit av;
      av = m_hold ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 5);
      drive(av, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));
      cycle("rand");
      if (n == 300) do_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
